// File: rtl/dmem_arbiter.sv
// ---------------------------------------------------------------------------
// dmem_arbiter
//   Two-requester arbiter for a single-port-write / single-port-read data
//   memory. Requester 0 is the CPU MEM stage, requester 1 is the loader.
//   After reset the block sweeps every memory word to zero (INIT), then
//   serves one transfer per cycle (RUN).
//
// Optional build macro:
//   DMEM_ARB_RR_EN  defined   -> round-robin arbitration (1-bit last_gnt)
//                   undefined -> fixed priority, requester 0 always wins
//
// Handshake: a transfer happens in a cycle where reqN_valid && reqN_ready.
//   reqN_ready is combinational from the valids and arbitration state and
//   never depends on any DUT output; a requester that is not granted must
//   hold its request stable. Writes complete in the transfer cycle with no
//   response. Reads return rspN_valid for exactly one cycle after the
//   transfer, with rspN_rdata holding its value while rspN_valid is low.
//
// Ports:
//   clk, rst                 clock, asynchronous active-high reset
//   reqN_valid/we/addr/wdata request from requester N (N = 0,1)
//   reqN_ready               grant for requester N
//   rspN_valid/rdata         read response for requester N
//   mem_we/wa/wd             memory write port
//   mem_ra/mem_rd            memory read port (address includes RD_OFS)
//   init_done                high from the first RUN cycle; this is the
//                            FSM state observation point (0=INIT, 1=RUN)
// ---------------------------------------------------------------------------
module dmem_arbiter #(
    parameter int NUM_WORDS = 64,
    parameter int AW        = 6,
    parameter int DW        = 32,
    parameter int RD_OFS    = 2
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          req0_valid,
    input  logic          req0_we,
    input  logic [AW-1:0] req0_addr,
    input  logic [DW-1:0] req0_wdata,
    input  logic          req1_valid,
    input  logic          req1_we,
    input  logic [AW-1:0] req1_addr,
    input  logic [DW-1:0] req1_wdata,
    output logic          req0_ready,
    output logic          req1_ready,
    output logic          rsp0_valid,
    output logic [DW-1:0] rsp0_rdata,
    output logic          rsp1_valid,
    output logic [DW-1:0] rsp1_rdata,
    output logic          mem_we,
    output logic [AW-1:0] mem_wa,
    output logic [DW-1:0] mem_wd,
    output logic [AW-1:0] mem_ra,
    input  logic [DW-1:0] mem_rd,
    output logic          init_done
);

    typedef enum logic {
        ST_INIT = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t        r_state;
    logic [AW-1:0] r_init_cnt;
    logic          r_rsp0_valid;
    logic          r_rsp1_valid;
    logic [DW-1:0] r_rsp0_rdata;
    logic [DW-1:0] r_rsp1_rdata;
`ifdef DMEM_ARB_RR_EN
    logic          r_last_gnt;
`endif

    logic          w_gnt0;
    logic          w_gnt1;
    logic          w_xfer;
    logic          w_init;
    logic [AW-1:0] w_addr;
    logic          w_we;
    logic [DW-1:0] w_wdata;

    assign w_init = (r_state == ST_INIT);

    // Grant logic. Nothing is granted while the init sweep owns the memory.
    always_comb begin
        w_gnt0 = 1'b0;
        w_gnt1 = 1'b0;
        if (!w_init) begin
`ifdef DMEM_ARB_RR_EN
            // On contention, grant whoever was not granted last.
            w_gnt1 = req1_valid && (!req0_valid || !r_last_gnt);
            w_gnt0 = req0_valid && !w_gnt1;
`else
            w_gnt0 = req0_valid;
            w_gnt1 = req1_valid && !req0_valid;
`endif
        end
    end

    assign w_xfer     = w_gnt0 | w_gnt1;
    assign req0_ready = w_gnt0;
    assign req1_ready = w_gnt1;

    // Address/data mux: requester 1 only when granted, otherwise requester 0,
    // so the read address keeps tracking req0 when idle.
    assign w_addr  = w_gnt1 ? req1_addr  : req0_addr;
    assign w_we    = w_gnt1 ? req1_we    : req0_we;
    assign w_wdata = w_gnt1 ? req1_wdata : req0_wdata;

    assign mem_we = w_init | (w_xfer & w_we);
    assign mem_wa = w_init ? r_init_cnt : w_addr;
    assign mem_wd = w_init ? '0 : w_wdata;
    // Memory read port returns data for (ra - RD_OFS); pre-add to compensate.
    assign mem_ra = w_addr + AW'(RD_OFS);

    assign rsp0_valid = r_rsp0_valid;
    assign rsp1_valid = r_rsp1_valid;
    assign rsp0_rdata = r_rsp0_rdata;
    assign rsp1_rdata = r_rsp1_rdata;
    assign init_done  = (r_state == ST_RUN);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state    <= ST_INIT;
            r_init_cnt <= '0;
        end else begin
            case (r_state)
                ST_INIT: begin
                    if (r_init_cnt == AW'(NUM_WORDS - 1)) begin
                        r_state    <= ST_RUN;
                        r_init_cnt <= '0;
                    end else begin
                        r_init_cnt <= r_init_cnt + 1'b1;
                    end
                end
                default: r_state <= ST_RUN;
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_rsp0_valid <= 1'b0;
            r_rsp1_valid <= 1'b0;
            r_rsp0_rdata <= '0;
            r_rsp1_rdata <= '0;
        end else begin
            r_rsp0_valid <= w_gnt0 & ~req0_we;
            r_rsp1_valid <= w_gnt1 & ~req1_we;
            if (w_gnt0 && !req0_we) r_rsp0_rdata <= mem_rd;
            if (w_gnt1 && !req1_we) r_rsp1_rdata <= mem_rd;
        end
    end

`ifdef DMEM_ARB_RR_EN
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_last_gnt <= 1'b0;
        end else if (w_xfer) begin
            r_last_gnt <= w_gnt1;
        end
    end
`endif

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    localparam int AW = 6;
    localparam int DW = 32;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          req0_valid = 1'b0, req0_we = 1'b0;
    logic [AW-1:0] req0_addr = '0;
    logic [DW-1:0] req0_wdata = '0;
    logic          req1_valid = 1'b0, req1_we = 1'b0;
    logic [AW-1:0] req1_addr = '0;
    logic [DW-1:0] req1_wdata = '0;
    logic          req0_ready, req1_ready, rsp0_valid, rsp1_valid;
    logic [DW-1:0] rsp0_rdata, rsp1_rdata;
    logic          mem_we, init_done;
    logic [AW-1:0] mem_wa, mem_ra;
    logic [DW-1:0] mem_wd, mem_rd;

    int n_vec = 0;
    int n_err = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    dmem_arbiter #(.NUM_WORDS(64), .AW(AW), .DW(DW), .RD_OFS(2)) dut (
        .clk(clk), .rst(rst),
        .req0_valid(req0_valid), .req0_we(req0_we), .req0_addr(req0_addr), .req0_wdata(req0_wdata),
        .req1_valid(req1_valid), .req1_we(req1_we), .req1_addr(req1_addr), .req1_wdata(req1_wdata),
        .req0_ready(req0_ready), .req1_ready(req1_ready),
        .rsp0_valid(rsp0_valid), .rsp0_rdata(rsp0_rdata),
        .rsp1_valid(rsp1_valid), .rsp1_rdata(rsp1_rdata),
        .mem_we(mem_we), .mem_wa(mem_wa), .mem_wd(mem_wd),
        .mem_ra(mem_ra), .mem_rd(mem_rd), .init_done(init_done)
    );

    // Data memory model: write on the edge, read port offset by RD_OFS.
    logic [DW-1:0] tb_mem [64];
    logic [AW-1:0] mem_ra_m2;
    assign mem_ra_m2 = mem_ra - 6'd2;
    assign mem_rd    = tb_mem[mem_ra_m2];
    always @(posedge clk) if (mem_we) tb_mem[mem_wa] <= mem_wd;

    // ---------------- checker ----------------
    task automatic chk(input string tag, input logic [DW-1:0] got, input logic [DW-1:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive0(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req0_valid = v; req0_we = we; req0_addr = a; req0_wdata = d;
    endtask

    task automatic drive1(input logic v, input logic we, input logic [AW-1:0] a, input logic [DW-1:0] d);
        req1_valid = v; req1_we = we; req1_addr = a; req1_wdata = d;
    endtask

    localparam logic [DW-1:0] D10 = 32'h1234_5678;
    localparam logic [DW-1:0] D20 = 32'hA5A5_0014;

    int exp_g [4];
    int prev_g;

    initial begin
        // ---- reset state ----
        #2;
        chk("rst_init_done", {31'd0, init_done}, 32'd0);
        chk("rst_rsp0_valid", {31'd0, rsp0_valid}, 32'd0);
        chk("rst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("rst_rsp0_rdata", rsp0_rdata, 32'd0);
        chk("rst_rsp1_rdata", rsp1_rdata, 32'd0);
        chk("rst_mem_wa", {26'd0, mem_wa}, 32'd0);
        #10 rst = 1'b0;
        #1;

        // ---- init sweep: 64 writes of zero, one per cycle ----
        for (int c = 0; c < 64; c++) begin
            chk("init_we", {31'd0, mem_we}, 32'd1);
            chk("init_wa", {26'd0, mem_wa}, c);
            chk("init_wd", mem_wd, 32'd0);
            chk("init_done_low", {31'd0, init_done}, 32'd0);
            step();
        end
        chk("init_done_high", {31'd0, init_done}, 32'd1);
        chk("run_idle_we", {31'd0, mem_we}, 32'd0);

        // ---- req0 write 5, then read 5 ----
        drive0(1, 1, 6'd5, 32'hDEAD_BEEF); #1;
        chk("wr_ready0", {31'd0, req0_ready}, 32'd1);
        chk("wr_ready1", {31'd0, req1_ready}, 32'd0);
        chk("wr_we", {31'd0, mem_we}, 32'd1);
        chk("wr_wa", {26'd0, mem_wa}, 32'd5);
        chk("wr_wd", mem_wd, 32'hDEAD_BEEF);
        step();
        drive0(1, 0, 6'd5, 32'd0); #1;
        chk("rd_ready0", {31'd0, req0_ready}, 32'd1);
        chk("rd_we", {31'd0, mem_we}, 32'd0);
        chk("rd_ra", {26'd0, mem_ra}, 32'd7);
        chk("wr_no_rsp", {31'd0, rsp0_valid}, 32'd0);
        step();
        drive0(0, 0, 6'd0, 32'd0); #1;
        chk("rd_rsp0_valid", {31'd0, rsp0_valid}, 32'd1);
        chk("rd_rsp0_rdata", rsp0_rdata, 32'hDEAD_BEEF);
        chk("rd_rsp1_quiet", {31'd0, rsp1_valid}, 32'd0);
        step();
        chk("rsp0_one_cycle", {31'd0, rsp0_valid}, 32'd0);
        chk("rsp0_hold", rsp0_rdata, 32'hDEAD_BEEF);

        // ---- set up data: req0 writes 10, req1 writes 20 ----
        drive0(1, 1, 6'd10, D10); #1;
        chk("wr10_ready0", {31'd0, req0_ready}, 32'd1);
        step();
        drive0(0, 0, 6'd0, 32'd0);
        drive1(1, 1, 6'd20, D20); #1;
        chk("wr20_ready1", {31'd0, req1_ready}, 32'd1);
        chk("wr20_wa", {26'd0, mem_wa}, 32'd20);
        chk("wr20_wd", mem_wd, D20);
        step();

        // ---- both requesters reading for 4 cycles ----
`ifdef DMEM_ARB_RR_EN
        // last grant was requester 1, so contention starts with requester 0
        exp_g = '{0, 1, 0, 1};
`else
        exp_g = '{0, 0, 0, 0};
`endif
        prev_g = -1;
        drive0(1, 0, 6'd10, 32'd0);
        drive1(1, 0, 6'd20, 32'd0);
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("both_ready0", {31'd0, req0_ready}, (exp_g[i] == 0) ? 32'd1 : 32'd0);
            chk("both_ready1", {31'd0, req1_ready}, (exp_g[i] == 1) ? 32'd1 : 32'd0);
            chk("both_ra", {26'd0, mem_ra}, (exp_g[i] == 0) ? 32'd12 : 32'd22);
            if (prev_g >= 0) begin
                chk("both_rsp0_valid", {31'd0, rsp0_valid}, (prev_g == 0) ? 32'd1 : 32'd0);
                chk("both_rsp1_valid", {31'd0, rsp1_valid}, (prev_g == 1) ? 32'd1 : 32'd0);
                if (prev_g == 0) chk("both_rsp0_rdata", rsp0_rdata, D10);
                else             chk("both_rsp1_rdata", rsp1_rdata, D20);
            end
            prev_g = exp_g[i];
            step();
        end

        // ---- req0 drops: req1 granted at once ----
        drive0(0, 0, 6'd0, 32'd0); #1;
        chk("drop_ready1", {31'd0, req1_ready}, 32'd1);
        chk("drop_ready0", {31'd0, req0_ready}, 32'd0);
        chk("drop_ra", {26'd0, mem_ra}, 32'd22);
        chk("drop_prev_rsp0", {31'd0, rsp0_valid}, (prev_g == 0) ? 32'd1 : 32'd0);
        chk("drop_prev_rsp1", {31'd0, rsp1_valid}, (prev_g == 1) ? 32'd1 : 32'd0);
        step();

        // ---- req1 read 63 wraps the read address ----
        drive1(1, 0, 6'd63, 32'd0); #1;
        chk("wrap_ready1", {31'd0, req1_ready}, 32'd1);
        chk("wrap_ra", {26'd0, mem_ra}, 32'd1);
        chk("r20_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("r20_rsp1_rdata", rsp1_rdata, D20);
        step();
        drive1(0, 0, 6'd0, 32'd0); #1;
        chk("r63_rsp1_valid", {31'd0, rsp1_valid}, 32'd1);
        chk("r63_rsp1_rdata", rsp1_rdata, 32'd0);

        // ---- reset in the response cycle ----
        #1 rst = 1'b1; #1;
        chk("arst_rsp1_valid", {31'd0, rsp1_valid}, 32'd0);
        chk("arst_rsp1_rdata", rsp1_rdata, 32'd0);
        chk("arst_init_done", {31'd0, init_done}, 32'd0);
        chk("arst_we", {31'd0, mem_we}, 32'd1);
        chk("arst_wa", {26'd0, mem_wa}, 32'd0);
        drive0(1, 0, 6'd3, 32'd0);
        step();
        rst = 1'b0; #1;
        chk("reinit_ready0", {31'd0, req0_ready}, 32'd0);
        chk("reinit_wa0", {26'd0, mem_wa}, 32'd0);
        step();
        chk("reinit_wa1", {26'd0, mem_wa}, 32'd1);
        chk("reinit_ready0_b", {31'd0, req0_ready}, 32'd0);

        // ---- report ----
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/dmem_arbiter.md
DMEM_ARBITER -- requirements
Module: dmem_arbiter

Interface
REQ-001 SHALL have parameter NUM_WORDS, default 64: number of data-memory words swept by init.
REQ-002 SHALL have parameter AW, default 6: word address width.
REQ-003 SHALL have parameter DW, default 32: data width.
REQ-004 SHALL have parameter RD_OFS, default 2: offset added to the read address to compensate the data-memory read-port offset.
REQ-005 SHALL have port clk  input  1  single clock, all state on rising edge.
REQ-006 SHALL have port rst  input  1  asynchronous, active-high reset.
REQ-007 SHALL have, for n in {0,1}, ports reqn_valid input 1, reqn_we input 1, reqn_addr input AW, reqn_wdata input DW: request from requester n (0 = CPU MEM stage, 1 = loader).
REQ-008 SHALL have, for n in {0,1}, ports reqn_ready output 1, rspn_valid output 1, rspn_rdata output DW: grant and read response.
REQ-009 SHALL have ports mem_we output 1, mem_wa output AW, mem_wd output DW, mem_ra output AW, mem_rd input DW: data-memory side.
REQ-010 SHALL have port init_done output 1: high once the init sweep completes.

Function
REQ-011 FSM SHALL have states INIT and RUN; reset enters INIT.
REQ-012 In INIT, each cycle: mem_we=1, mem_wa=init_cnt, mem_wd=0, init_cnt+1; both reqn_ready=0.
REQ-013 INIT SHALL last exactly NUM_WORDS cycles (words 0..NUM_WORDS-1 written), then move to RUN, with init_done=1 from the first RUN cycle.
REQ-014 In RUN, at most one requester SHALL be granted per cycle; reqn_ready is combinational from valids and the arbitration state, and is high only for the granted requester with reqn_valid=1.
REQ-015 A transfer SHALL occur in a cycle where reqn_valid and reqn_ready are both 1; requests not granted SHALL be held stable by the requester.
REQ-016 Write transfer: mem_we=1, mem_wa=reqn_addr, mem_wd=reqn_wdata in the same cycle; no response is generated.
REQ-017 Read transfer: mem_ra=(reqn_addr+RD_OFS) mod 2^AW; mem_rd is registered into rspn_rdata at the clock edge ending the cycle; rspn_valid=1 for exactly the following cycle (latency 1).
REQ-018 Outside write transfers and INIT, mem_we SHALL be 0; mem_ra SHALL still track the granted (or req0) address.
REQ-019 rspn_rdata SHALL hold its last value while rspn_valid=0.
REQ-020 A read one cycle after a write to the same address SHALL return the newly written data.
REQ-021 Back-to-back transfers SHALL be sustained at one per cycle with no bubble.

Reset
REQ-022 Asserting rst at any time SHALL immediately force INIT, init_cnt=0, init_done=0, rsp0_valid=rsp1_valid=0, rsp0_rdata=rsp1_rdata=0, and the round-robin pointer to 0; an in-flight read response is discarded.
REQ-023 After reset deassertion, the first INIT write SHALL occur on the first rising edge.

Configuration
REQ-024 Macro DMEM_ARB_RR_EN defined: round-robin arbitration; 1-bit pointer last_gnt; with both valid, grant the requester not equal to last_gnt; last_gnt updates only on a transfer.
REQ-025 Macro DMEM_ARB_RR_EN undefined: fixed priority, req0 always wins; no pointer state.

Verification
REQ-026 Reset released, no requests -> mem_we=1 for exactly 64 cycles, mem_wa 0..63, mem_wd=0; init_done rises in cycle 65.
REQ-027 RUN, req0 write addr 5 data 0xDEADBEEF, next cycle req0 read addr 5 -> mem_ra=7, rsp0_valid one cycle later with rsp0_rdata=0xDEADBEEF.
REQ-028 RR on, req0 and req1 both reading continuously -> grants alternate 0,1,0,1; rsp0_valid and rsp1_valid alternate each cycle.
REQ-029 RR off, both valid for 4 cycles -> req0_ready=1 throughout, req1_ready=0; req1 granted in the cycle req0_valid drops.
REQ-030 req1 read addr 63 -> mem_ra=1 (wrap); rst asserted in the response cycle -> rsp1_valid=0 immediately and INIT restarts at word 0.
